// File: rtl/write_buffer_if.sv
// AHB-Lite slave bus plus Y-port handshake for the write_buffer block.
// Signal names follow the AHB / Y-port naming used by the rest of the system.
interface write_buffer_if;
  // AHB-Lite slave side
  logic        HWRITE;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HADDR;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  // Y-port towards the slow consumer
  logic        YACK;
  logic        YREQ;
  logic [31:0] YDATA;
  logic        YPARITY;
  // Run-time parity select: 1 = odd, 0 = even
  logic        PARTYSEL;

  // The block itself
  modport slave (
    input  HWRITE, HSEL, HTRANS, HSIZE, HWDATA, HADDR, HREADY, YACK, PARTYSEL,
    output HREADYOUT, HRDATA, YREQ, YDATA, YPARITY
  );

  // Bus master / consumer environment around the block
  modport master (
    output HWRITE, HSEL, HTRANS, HSIZE, HWDATA, HADDR, HREADY, YACK, PARTYSEL,
    input  HREADYOUT, HRDATA, YREQ, YDATA, YPARITY
  );
endinterface

// File: rtl/write_buffer.sv
// write_buffer: AHB-Lite posted-write buffer. Writes are pushed into a small
// circular FIFO and drained one word at a time over a four-phase req/ack
// Y-port with a selectable-parity bit. Reads return a status word. The bus is
// stalled only while a write is pending against a full FIFO.
module write_buffer #(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic HCLK,
  input  logic HRESET,     // asynchronous, active-low
  write_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    Y_IDLE    = 2'd0,
    Y_REQ     = 2'd1,
    Y_WAITLOW = 2'd2
  } y_state_e;

  // Storage and FIFO bookkeeping
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Data-phase flags captured from the accepted address phase
  logic pend_q, pend_d;   // a write data phase is outstanding
  logic rd_q, rd_d;       // a read data phase is in progress

  // Y-port state and registered outputs
  y_state_e    state_q;
  logic        yreq_q;
  logic [31:0] ydata_q;

  logic        accept;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        ready_out;
  logic [31:0] count_w;
  logic [31:0] status;

  // Size and address are not decoded: single word-wide register slave.
  logic unused_inputs;
  assign unused_inputs = ^{bus.HSIZE, bus.HADDR};

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  // The head is consumed when the consumer acknowledges an outstanding request.
  assign pop  = (state_q == Y_REQ) & bus.YACK;
  // A pending write lands as soon as there is room, including room made by a
  // pop in the very same cycle.
  assign push = pend_q & (~full | pop);

  // Wait only while the pending write cannot land this cycle.
  assign ready_out = ~(pend_q & full & ~pop);

  assign count_w = 32'(count_q);
  assign status  = {24'b0, count_w[3:0], 2'b0, full, empty};

  // Next-state for the bus data-phase flags
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pend_d = pend_q & ~push;
    rd_d   = rd_q;
    if (bus.HREADY & ready_out) begin
      pend_d = accept & bus.HWRITE;
      rd_d   = accept & ~bus.HWRITE;
    end
  end

  // Next-state for pointers and occupancy count
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Bus flags and FIFO bookkeeping registers
  always_ff @(posedge HCLK or negedge HRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!HRESET) begin
      pend_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      rd_q     <= rd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge HCLK) begin
    // NOTE: the data array is deliberately not reset; the count and pointers
    // define which entries are valid, so clearing storage buys nothing.
    if (push) begin
      mem[wr_ptr_q] <= bus.HWDATA;
    end
  end

  // Y-port four-phase handshake with registered YREQ/YDATA
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= Y_IDLE;
      yreq_q  <= 1'b0;
      ydata_q <= '0;
    end else begin
      case (state_q)
        Y_IDLE: begin
          // The head is latched into YDATA here, so the slot can be reused by
          // a push in the same cycle as its later pop.
          if (!empty) begin
            state_q <= Y_REQ;
            yreq_q  <= 1'b1;
            ydata_q <= mem[rd_ptr_q];
          end
        end
        Y_REQ: begin
          if (bus.YACK) begin
            state_q <= Y_WAITLOW;
            yreq_q  <= 1'b0;
          end
        end
        Y_WAITLOW: begin
          // Guarantees at least one cycle of YREQ low between words.
          if (!bus.YACK) begin
            state_q <= Y_IDLE;
          end
        end
        default: begin
          state_q <= Y_IDLE;
          yreq_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = ready_out;
  assign bus.HRDATA    = rd_q ? status : 32'h0;
  assign bus.YREQ      = yreq_q;
  assign bus.YDATA     = ydata_q;
  // Parity follows PARTYSEL combinationally, even mid-request.
  assign bus.YPARITY   = (^ydata_q) ^ bus.PARTYSEL;

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based behavioural model.
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;

  logic clk;
  logic rst_n;

  write_buffer_if bus ();

  // Single slave on the bus: the bus-wide ready is this slave's ready.
  assign bus.HREADY = bus.HREADYOUT;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .HCLK   (clk),
    .HRESET (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] mq[$];      // words accepted but not yet consumed
  bit          m_pend;     // write data phase outstanding
  bit          m_rd;       // read data phase in progress
  int          m_ph;       // 0 idle, 1 requesting, 2 waiting for YACK low
  logic [31:0] m_ydata;
  bit          prev_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = mq.size();
    return {24'b0, 4'(n), 2'b0, (n == DEPTH), (n == 0)};
  endfunction

  function automatic bit model_ready();
    bit pop;
    pop = (m_ph == 1) && bus.YACK;
    return !(m_pend && (mq.size() == DEPTH) && !pop);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend     = 1'b0;
    m_rd       = 1'b0;
    m_ph       = 0;
    m_ydata    = 32'h0;
    prev_ready = 1'b1;
  endtask

  task automatic compare_all();
    chk("hreadyout", 32'(bus.HREADYOUT), 32'(model_ready()));
    chk("yreq",      32'(bus.YREQ),      32'(m_ph == 1));
    chk("ydata",     bus.YDATA,          m_ydata);
    chk("yparity",   32'(bus.YPARITY),   32'((^m_ydata) ^ bus.PARTYSEL));
    chk("hrdata",    bus.HRDATA,         m_rd ? model_status() : 32'h0);
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    bit          pop, push, full, rdy, go;
    logic [31:0] head;
    full = (mq.size() == DEPTH);
    pop  = (m_ph == 1) && bus.YACK;
    push = m_pend && (!full || pop);
    rdy  = model_ready();
    go   = (m_ph == 0) && (mq.size() > 0);
    head = go ? mq[0] : 32'h0;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(bus.HWDATA);
    if (go) begin
      m_ph    = 1;
      m_ydata = head;
    end else if (m_ph == 1 && bus.YACK) begin
      m_ph = 2;
    end else if (m_ph == 2 && !bus.YACK) begin
      m_ph = 0;
    end
    if (rdy) begin
      m_pend = bus.HSEL && bus.HTRANS[1] && bus.HWRITE;
      m_rd   = bus.HSEL && bus.HTRANS[1] && !bus.HWRITE;
    end
    prev_ready = rdy;
  endtask

  // One bus cycle: drive after the falling edge, compare, cross the rising edge.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [31:0] wd, input logic ack, input logic ps);
    bus.HSEL     = sel;
    bus.HTRANS   = tr;
    bus.HWRITE   = wr;
    bus.HWDATA   = wd;
    bus.YACK     = ack;
    bus.PARTYSEL = ps;
    bus.HSIZE    = 3'd2;
    bus.HADDR    = $urandom;
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic ack, input logic ps);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0, ack, ps);
  endtask

  // Wait (bounded) for a request, record the word, then complete the handshake.
  task automatic drain_one(input logic ps, output logic [31:0] w);
    int n;
    n = 0;
    while (!bus.YREQ && n < 20) begin
      idle_cyc(1'b0, ps);
      n++;
    end
    chk("yreq_wait", 32'(bus.YREQ), 32'd1);
    w = bus.YDATA;
    idle_cyc(1'b1, ps);
    idle_cyc(1'b0, ps);
  endtask

  task automatic do_reset();
    bus.HSEL   = 1'b0;
    bus.HTRANS = T_IDLE;
    bus.HWRITE = 1'b0;
    bus.YACK   = 1'b0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    chk("rst_yreq",      32'(bus.YREQ),      32'd0);
    chk("rst_ydata",     bus.YDATA,          32'h0);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hrdata",    bus.HRDATA,         32'h0);
    chk("rst_yparity",   32'(bus.YPARITY),   32'(bus.PARTYSEL));
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  logic [31:0] drained[$];
  logic [31:0] w;
  logic        r_sel, r_wr, r_ack, r_ps;
  logic [1:0]  r_tr;
  logic [31:0] r_wd;

  initial begin
    bus.PARTYSEL = 1'b0;
    bus.HSIZE    = 3'd2;
    bus.HADDR    = 32'h0;
    bus.HWDATA   = 32'h0;
    rst_n        = 1'b1;
    @(negedge clk);
    do_reset();

    // Single write, even parity
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, T_IDLE, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    chk("single_no_req_yet", 32'(bus.YREQ), 32'd0);
    idle_cyc(1'b0, 1'b0);
    chk("single_yreq",    32'(bus.YREQ),    32'd1);
    chk("single_ydata",   bus.YDATA,        32'h0000_0001);
    chk("single_yparity", 32'(bus.YPARITY), 32'd1);
    idle_cyc(1'b1, 1'b0);
    chk("single_yreq_low", 32'(bus.YREQ), 32'd0);
    cyc(1'b1, T_NONSEQ, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("single_status", bus.HRDATA, 32'h0000_0001);
    idle_cyc(1'b0, 1'b0);

    // Parity select while requesting
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, T_IDLE, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle_cyc(1'b0, 1'b1);
    chk("par_odd", 32'(bus.YPARITY), 32'd1);
    bus.PARTYSEL = 1'b0;
    #1;
    chk("par_even", 32'(bus.YPARITY), 32'd0);
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b0, 1'b0);

    // IDLE-type and read transfers push nothing
    cyc(1'b1, T_IDLE, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("idle_read_status", bus.HRDATA, 32'h0000_0001);
    idle_cyc(1'b0, 1'b0);

    // Fill with YACK held low, then stall a fifth write
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h0,  1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'hA0, 1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'hA1, 1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'hA2, 1'b0, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b0, 32'hA3, 1'b0, 1'b0);
    chk("fill_status", bus.HRDATA, 32'h0000_0042);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h0, 1'b0, 1'b0);
    drained.delete();
    cyc(1'b0, T_IDLE, 1'b0, 32'hA4, 1'b0, 1'b0);
    chk("stall_hreadyout", 32'(bus.HREADYOUT), 32'd0);
    cyc(1'b0, T_IDLE, 1'b0, 32'hA4, 1'b0, 1'b0);
    chk("stall_head", bus.YDATA, 32'hA0);
    drained.push_back(bus.YDATA);
    bus.YACK = 1'b1;
    #1;
    chk("pop_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    cyc(1'b0, T_IDLE, 1'b0, 32'hA4, 1'b1, 1'b0);
    cyc(1'b1, T_NONSEQ, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pushpop_status", bus.HRDATA, 32'h0000_0042);
    for (int i = 0; i < 4; i++) begin
      drain_one(1'b0, w);
      drained.push_back(w);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_%0d", i), (i < drained.size()) ? drained[i] : 32'hX, 32'hA0 + 32'(i));
    end

    // Reset while requesting with three words queued
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h0,  1'b0, 1'b1);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h11, 1'b0, 1'b1);
    cyc(1'b1, T_NONSEQ, 1'b1, 32'h22, 1'b0, 1'b1);
    cyc(1'b0, T_IDLE,   1'b0, 32'h33, 1'b0, 1'b1);
    chk("pre_reset_yreq", 32'(bus.YREQ), 32'd1);
    do_reset();
    cyc(1'b1, T_NONSEQ, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("post_reset_status", bus.HRDATA, 32'h0000_0001);
    idle_cyc(1'b0, 1'b1);

    // Randomized traffic; address/data held while the slave stalls
    r_sel = 1'b0; r_tr = T_IDLE; r_wr = 1'b0; r_wd = 32'h0; r_ps = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_ready) begin
        r_sel = ($urandom_range(0, 3) != 0);
        r_tr  = 2'($urandom_range(0, 3));
        r_wr  = ($urandom_range(0, 2) != 0);
        r_wd  = $urandom;
      end
      r_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) r_ps = ~r_ps;
      cyc(r_sel, r_tr, r_wr, r_wd, r_ack, r_ps);
      if (c == 1500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
